// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
`default_nettype none

package program_loader_pkg;

   localparam int         LEN_WIDTH         = 16;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_CHECK  = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream little-endian into STEP-byte words; last flags the byte that completes a word.
`default_nettype none

module word_assembler #(
   parameter int STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [7:0]        byte_in,
   output logic [STEP*8-1:0] word,
   output logic              last
);

   localparam int IDX_W = (STEP > 1) ? $clog2(STEP) : 1;

   logic [IDX_W-1:0] idx;

   assign last = (idx == IDX_W'(STEP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         word <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (load) begin
         for (int k = 0; k < STEP; k++) begin
            if (idx == IDX_W'(k)) word[8*k +: 8] <= byte_in;
         end
         idx <= last ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// Framed serial loader: sync, 16-bit word count, payload, 8-bit additive checksum.
`default_nettype none

module program_loader
   import program_loader_pkg::*;
#(
   parameter int         INSTR_ADDR_WIDTH = 20,
   parameter int         STEP             = 4,
   parameter logic [7:0] SYNC_BYTE        = DEFAULT_SYNC_BYTE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic                        pgm,
   output logic [INSTR_ADDR_WIDTH-1:0] addr,
   output logic [STEP*8-1:0]           data,
   output logic                        busy,
   output logic                        done,
   output logic                        error
);

   // Largest legal word count; a count field can never exceed it once the address space reaches 16 bits.
   localparam logic [LEN_WIDTH:0] MAX_WORDS = (INSTR_ADDR_WIDTH >= LEN_WIDTH) ?
                                              {(LEN_WIDTH+1){1'b1}} :
                                              ((LEN_WIDTH+1)'(1) << INSTR_ADDR_WIDTH);

   state_t               state, next_state;
   logic [7:0]           len_lo;
   logic [LEN_WIDTH-1:0] remaining;
   logic [7:0]           csum;
   logic                 accept;
   logic                 is_sync;
   logic [LEN_WIDTH-1:0] word_count;
   logic                 len_too_big;
   logic                 asm_last;

   assign accept      = rx_valid && rx_ready;
   assign is_sync     = (rx_data == SYNC_BYTE);
   assign word_count  = {rx_data, len_lo};
   assign len_too_big = ({1'b0, word_count} > MAX_WORDS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      rx_ready   = 1'b1;
      pgm        = 1'b0;
      busy       = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (accept && is_sync) next_state = ST_LEN_LO;
         end
         ST_LEN_LO: if (accept) next_state = ST_LEN_HI;
         ST_LEN_HI: begin
            if (accept) begin
               if (len_too_big)             next_state = ST_IDLE;
               else if (word_count == '0)   next_state = ST_CHECK;
               else                         next_state = ST_DATA;
            end
         end
         ST_DATA: if (accept && asm_last) next_state = ST_WRITE;
         ST_WRITE: begin
            rx_ready   = 1'b0;
            pgm        = 1'b1;
            next_state = (remaining == LEN_WIDTH'(1)) ? ST_CHECK : ST_DATA;
         end
         ST_CHECK: if (accept) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo    <= '0;
         remaining <= '0;
         csum      <= '0;
         addr      <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && is_sync) begin
                  done  <= 1'b0;
                  error <= 1'b0;
                  csum  <= '0;
                  addr  <= '0;
               end
            end
            ST_LEN_LO: if (accept) len_lo <= rx_data;
            ST_LEN_HI: begin
               if (accept) begin
                  remaining <= word_count;
                  if (len_too_big) error <= 1'b1;
               end
            end
            ST_DATA: if (accept) csum <= csum + rx_data;
            ST_WRITE: begin
               // Wraps to 0 only after the final write of a full-address-space load.
               addr      <= addr + INSTR_ADDR_WIDTH'(1);
               remaining <= remaining - LEN_WIDTH'(1);
            end
            ST_CHECK: begin
               if (accept) begin
                  if (rx_data == csum) done  <= 1'b1;
                  else                 error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   word_assembler #(
      .STEP (STEP)
   ) u_word_assembler (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   ((state == ST_IDLE) && accept && is_sync),
      .load    ((state == ST_DATA) && accept),
      .byte_in (rx_data),
      .word    (data),
      .last    (asm_last)
   );

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// Directed and randomized frame tests for program_loader against a frame-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_program_loader;

   localparam int AW   = 5;
   localparam int STEP = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0;
   logic             rx_ready;
   logic             pgm;
   logic [AW-1:0]    addr;
   logic [STEP*8-1:0] data;
   logic             busy;
   logic             done;
   logic             error;

   int vectors     = 0;
   int miscompares = 0;
   int ready_low   = 0;
   int busy_cycles = 0;
   logic [AW+STEP*8-1:0] got[$];

   program_loader #(
      .INSTR_ADDR_WIDTH (AW),
      .STEP             (STEP),
      .SYNC_BYTE        (8'hA5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .pgm      (pgm),
      .addr     (addr),
      .data     (data),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Observer: every pgm pulse becomes one recorded write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pgm)       got.push_back({addr, data});
         if (!rx_ready) ready_low++;
         if (busy)      busy_cycles++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called and returns on a falling edge; the byte is transferred on the rising edge in between.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      guard    = 0;
      while (!rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("ready_timeout", 64'(rx_ready), 64'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_list(input logic [7:0] q[$], input int maxgap);
      foreach (q[i]) send_byte(q[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
   endtask

   // Reference model: a frame of n random words yields writes i -> word i and checksum = byte sum mod 256.
   task automatic run_frame(input int n, input bit corrupt, input int maxgap, input string tag);
      logic [7:0]  fb[$];
      logic [31:0] words[$];
      logic [7:0]  sum;
      logic [31:0] w;
      sum = 8'h00;
      fb.push_back(8'hA5);
      fb.push_back(8'(n));
      fb.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         words.push_back(w);
         for (int k = 0; k < STEP; k++) begin
            fb.push_back(w[8*k +: 8]);
            sum = sum + w[8*k +: 8];
         end
      end
      fb.push_back(corrupt ? 8'(sum + 8'd1 + 8'($urandom_range(254, 0))) : sum);
      got.delete();
      ready_low = 0;
      send_list(fb, maxgap);
      check({tag, "_nwrites"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++)
         check({tag, "_write"}, 64'(got[i]), 64'({AW'(i), words[i]}));
      check({tag, "_ready_low"}, 64'(ready_low), 64'(n));
      check({tag, "_done"},  64'(done),  64'(!corrupt));
      check({tag, "_error"}, 64'(error), 64'(corrupt));
      check({tag, "_busy"},  64'(busy),  64'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      int n;

      repeat (2) @(negedge clk);
      check("rst_ready", 64'(rx_ready), 64'd1);
      check("rst_pgm",   64'(pgm),      64'd0);
      check("rst_addr",  64'(addr),     64'd0);
      check("rst_data",  64'(data),     64'd0);
      check("rst_flags", 64'({busy, done, error}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Known two-instruction frame
      got.delete();
      q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      send_list(q, 0);
      check("known_nwrites", 64'(got.size()), 64'd2);
      check("known_w0", 64'(got[0]), 64'({5'd0, 32'h00000013}));
      check("known_w1", 64'(got[1]), 64'({5'd1, 32'h00100093}));
      check("known_flags", 64'({done, error, busy}), 64'b100);

      // Length 33 exceeds the 32-word space
      got.delete();
      q = {8'hA5, 8'h21, 8'h00};
      send_list(q, 0);
      check("len_err_flags", 64'({done, error, busy}), 64'b010);
      busy_cycles = 0;
      q = {8'h13, 8'h00, 8'h00, 8'h00, 8'hB6};
      send_list(q, 0);
      check("len_err_nwrites", 64'(got.size()), 64'd0);
      check("len_err_idle", 64'(busy_cycles), 64'd0);

      // Junk before an empty frame
      busy_cycles = 0;
      q = {8'h00, 8'hFF, 8'h13};
      send_list(q, 0);
      check("junk_busy", 64'(busy_cycles), 64'd0);
      q = {8'hA5, 8'h00, 8'h00, 8'h00};
      send_list(q, 0);
      check("empty_busy_cycles", 64'(busy_cycles), 64'd3);
      check("empty_flags", 64'({done, error, busy}), 64'b100);
      check("empty_nwrites", 64'(got.size()), 64'd0);

      // Known frame with bad checksum: writes still happen
      got.delete();
      q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
      send_list(q, 0);
      check("badck_nwrites", 64'(got.size()), 64'd2);
      check("badck_w1", 64'(got[1]), 64'({5'd1, 32'h00100093}));
      check("badck_flags", 64'({done, error, busy}), 64'b010);

      run_frame(2, 1'b0, 4, "gap2");
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(8, 1));
         run_frame(n, 1'($urandom_range(1, 0)), 3, "rand");
      end
      run_frame(32, 1'b0, 1, "full");
      check("full_addr_wrap", 64'(addr), 64'd0);

      // Reset in the middle of the second payload word
      got.delete();
      q = {8'hA5, 8'h02, 8'h00};
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      send_list(q, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_pgm",   64'(pgm),      64'd0);
      check("midrst_ready", 64'(rx_ready), 64'd1);
      check("midrst_addr",  64'(addr),     64'd0);
      check("midrst_data",  64'(data),     64'd0);
      check("midrst_flags", 64'({busy, done, error}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(2, 1'b0, 2, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
